// File: rtl/nsadd_pkg.sv
// Shared types and constants for the nibble-serial adder/subtractor.
// Holds the FSM encoding, the slice width and the counter-width helper.
package nsadd_pkg;

   typedef enum logic [1:0] {
      NSADD_IDLE = 2'd0,
      NSADD_RUN  = 2'd1,
      NSADD_DONE = 2'd2
   } nsadd_state_e;

   localparam int NSADD_SLICE = 4;

   // A single-nibble engine still needs a 1-bit counter to have a legal vector.
   function automatic int nsadd_cnt_w(input int nibbles);
      return (nibbles > 1) ? $clog2(nibbles) : 1;
   endfunction

endpackage

// File: rtl/nsadd_slice4.sv
// Combinational 4-bit adder slice with carry in/out; the one 74AC283-equivalent in the engine.
module nsadd_slice4
   import nsadd_pkg::*;
(
   input  logic [NSADD_SLICE-1:0] i_a,
   input  logic [NSADD_SLICE-1:0] i_b,
   input  logic                   i_ci,
   output logic [NSADD_SLICE-1:0] o_s,
   output logic                   o_co
);

   assign {o_co, o_s} = {1'b0, i_a} + {1'b0, i_b} + {{NSADD_SLICE{1'b0}}, i_ci};

endmodule

// File: rtl/nibble_serial_addsub.sv
// Add/subtract one nibble per clock through a single slice: NIBBLES RUN cycles, result held in DONE until out_ready.
// Define NSADD_OVF_EN to add the registered signed-overflow output out_ovf.
module nibble_serial_addsub
   import nsadd_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_y,
   output logic             out_co
`ifdef NSADD_OVF_EN
   ,
   output logic             out_ovf
`endif
);

   localparam int NIBBLES = WIDTH / NSADD_SLICE;
   localparam int CNT_W   = nsadd_cnt_w(NIBBLES);

   generate
      if ((WIDTH % NSADD_SLICE) != 0 || WIDTH < NSADD_SLICE) begin : g_bad_width
         $error("nibble_serial_addsub: WIDTH must be a multiple of 4 and at least 4");
      end
   endgenerate

   nsadd_state_e r_state, w_state_nxt;

   logic [WIDTH-1:0]       r_a;
   logic [WIDTH-1:0]       r_b;
   logic [WIDTH-1:0]       r_y;
   logic [WIDTH-1:0]       w_y_nxt;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_cy;
   logic                   r_co;
   logic [NSADD_SLICE-1:0] w_s;
   logic                   w_co;
   logic                   w_accept;
   logic                   w_run;
   logic                   w_last;

   assign w_accept = (r_state == NSADD_IDLE) && in_valid;
   assign w_run    = (r_state == NSADD_RUN);
   assign w_last   = (r_cnt == CNT_W'(NIBBLES - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= NSADD_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         NSADD_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_state_nxt = NSADD_RUN;
         end
         NSADD_RUN: begin
            if (w_last) w_state_nxt = NSADD_DONE;
         end
         NSADD_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = NSADD_IDLE;
         end
         default: w_state_nxt = NSADD_IDLE;
      endcase
   end

   // Operands shift down so the active nibble is always bits [3:0].
   nsadd_slice4 u_slice (
      .i_a  (r_a[NSADD_SLICE-1:0]),
      .i_b  (r_b[NSADD_SLICE-1:0]),
      .i_ci (r_cy),
      .o_s  (w_s),
      .o_co (w_co)
   );

   generate
      if (NIBBLES == 1) begin : g_y_single
         assign w_y_nxt = w_s;
      end else begin : g_y_shift
         assign w_y_nxt = {w_s, r_y[WIDTH-1:NSADD_SLICE]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_a   <= '0;
         r_b   <= '0;
         r_y   <= '0;
         r_cnt <= '0;
         r_cy  <= 1'b0;
         r_co  <= 1'b0;
      end else if (w_accept) begin
         r_a   <= in_a;
         r_b   <= in_sub ? ~in_b : in_b;
         r_cy  <= in_sub;
         r_cnt <= '0;
      end else if (w_run) begin
         r_a   <= r_a >> NSADD_SLICE;
         r_b   <= r_b >> NSADD_SLICE;
         r_y   <= w_y_nxt;
         r_cy  <= w_co;
         r_cnt <= r_cnt + CNT_W'(1);
         if (w_last) r_co <= w_co;
      end
   end

   assign out_y  = r_y;
   assign out_co = r_co;

`ifdef NSADD_OVF_EN
   logic r_ovf;
   logic w_ci_msb;

   // Carry into the MSB recovered from the top bit of the final slice.
   assign w_ci_msb = r_a[NSADD_SLICE-1] ^ r_b[NSADD_SLICE-1] ^ w_s[NSADD_SLICE-1];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (w_run && w_last) begin
         r_ovf <= w_ci_msb ^ w_co;
      end
   end

   assign out_ovf = r_ovf;
`endif

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Randomized self-checking bench for nibble_serial_addsub at WIDTH 4, 16 and 32 against an arithmetic model.
module tb_nibble_serial_addsub;

   logic clk;
   logic rst_n;
   int   n_pass = 0;
   int   n_total = 0;

   logic       v4, v16, v32, or4, or16, or32, s4, s16, s32;
   logic       ir4, ir16, ir32, ov4, ov16, ov32, co4, co16, co32;
   logic [3:0]  a4, b4, y4;
   logic [15:0] a16, b16, y16;
   logic [31:0] a32, b32, y32;
`ifdef NSADD_OVF_EN
   logic f4, f16, f32;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   nibble_serial_addsub #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(ir4), .in_a(a4), .in_b(b4), .in_sub(s4),
      .out_valid(ov4), .out_ready(or4), .out_y(y4), .out_co(co4)
`ifdef NSADD_OVF_EN
      , .out_ovf(f4)
`endif
   );

   nibble_serial_addsub #(.WIDTH(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(ir16), .in_a(a16), .in_b(b16), .in_sub(s16),
      .out_valid(ov16), .out_ready(or16), .out_y(y16), .out_co(co16)
`ifdef NSADD_OVF_EN
      , .out_ovf(f16)
`endif
   );

   nibble_serial_addsub #(.WIDTH(32)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(ir32), .in_a(a32), .in_b(b32), .in_sub(s32),
      .out_valid(ov32), .out_ready(or32), .out_y(y32), .out_co(co32)
`ifdef NSADD_OVF_EN
      , .out_ovf(f32)
`endif
   );

   // Reference: plain modular arithmetic and signed range check.
   function automatic void model(input int w, input longint unsigned a_in, input longint unsigned b_in,
                                 input logic sub, output longint unsigned y, output logic co, output logic ovf);
      longint unsigned m, a, b;
      longint sa, sb, r, lim;
      m   = (64'd1 << w) - 64'd1;
      a   = a_in & m;
      b   = b_in & m;
      if (sub) begin
         y  = (a - b) & m;
         co = (a >= b);
      end else begin
         y  = (a + b) & m;
         co = ((a + b) >> w) != 64'd0;
      end
      lim = longint'(64'd1 << (w - 1));
      sa  = longint'(a);
      sb  = longint'(b);
      if (a[w-1]) sa = sa - 2 * lim;
      if (b[w-1]) sb = sb - 2 * lim;
      r   = sub ? (sa - sb) : (sa + sb);
      ovf = (r >= lim) || (r < -lim);
   endfunction

   task automatic drive(input int w, input logic v, input longint unsigned a, input longint unsigned b,
                        input logic s, input logic r);
      case (w)
         4: begin v4 = v; a4 = a[3:0]; b4 = b[3:0]; s4 = s; or4 = r; end
         32: begin v32 = v; a32 = a[31:0]; b32 = b[31:0]; s32 = s; or32 = r; end
         default: begin v16 = v; a16 = a[15:0]; b16 = b[15:0]; s16 = s; or16 = r; end
      endcase
   endtask

   function automatic logic g_rdy(input int w);
      case (w) 4: return ir4; 32: return ir32; default: return ir16; endcase
   endfunction
   function automatic logic g_ov(input int w);
      case (w) 4: return ov4; 32: return ov32; default: return ov16; endcase
   endfunction
   function automatic logic g_co(input int w);
      case (w) 4: return co4; 32: return co32; default: return co16; endcase
   endfunction
   function automatic longint unsigned g_y(input int w);
      case (w) 4: return 64'(y4); 32: return 64'(y32); default: return 64'(y16); endcase
   endfunction
   function automatic logic g_ovf(input int w);
`ifdef NSADD_OVF_EN
      case (w) 4: return f4; 32: return f32; default: return f16; endcase
`else
      return (w < 0);
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Latency is counted with the accept edge as edge 1.
   task automatic do_op(input int w, input longint unsigned a, input longint unsigned b, input logic s,
                        input longint unsigned ey, input logic eco, input logic eov, input string nm);
      int k;
      n_total++;
      if (g_rdy(w) !== 1'b1) $display("FAIL %s in_ready_before: got %b want 1", nm, g_rdy(w));
      else n_pass++;
      drive(w, 1'b1, a, b, s, 1'b0);
      tick();
      drive(w, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
      k = 1;
      while (g_ov(w) !== 1'b1 && k < 40) begin
         tick();
         k++;
      end
      n_total++;
      if (k !== w / 4 + 1) $display("FAIL %s latency: got %0d want %0d", nm, k, w / 4 + 1);
      else n_pass++;
      n_total++;
      if (g_y(w) !== ey) $display("FAIL %s out_y: got %h want %h", nm, g_y(w), ey);
      else n_pass++;
      n_total++;
      if (g_co(w) !== eco) $display("FAIL %s out_co: got %b want %b", nm, g_co(w), eco);
      else n_pass++;
`ifdef NSADD_OVF_EN
      n_total++;
      if (g_ovf(w) !== eov) $display("FAIL %s out_ovf: got %b want %b", nm, g_ovf(w), eov);
      else n_pass++;
`endif
      drive(w, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
      tick();
      drive(w, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
      n_total++;
      if (g_ov(w) !== 1'b0 || g_rdy(w) !== 1'b1)
         $display("FAIL %s release: got valid=%b ready=%b want valid=0 ready=1", nm, g_ov(w), g_rdy(w));
      else n_pass++;
   endtask

   task automatic rand_op(input int w, input string nm);
      longint unsigned a, b, ey;
      logic s, eco, eov;
      a = {32'($urandom), 32'($urandom)};
      b = {32'($urandom), 32'($urandom)};
      case ($urandom_range(5))
         0: a = 64'd0;
         1: a = ~64'd0;
         2: b = ~64'd0;
         3: b = a;
         default: ;
      endcase
      a = a & ((64'd1 << w) - 64'd1);
      b = b & ((64'd1 << w) - 64'd1);
      s = 1'($urandom_range(1));
      model(w, a, b, s, ey, eco, eov);
      do_op(w, a, b, s, ey, eco, eov, nm);
   endtask

   task automatic test_reset();
      int ws[3] = '{4, 16, 32};
      rst_n = 1'b0;
      repeat (3) tick();
      foreach (ws[i]) begin
         n_total++;
         if (g_rdy(ws[i]) !== 1'b1 || g_ov(ws[i]) !== 1'b0 || g_y(ws[i]) !== 64'd0 ||
             g_co(ws[i]) !== 1'b0 || g_ovf(ws[i]) !== 1'b0)
            $display("FAIL reset_w%0d: got ready=%b valid=%b y=%h co=%b ovf=%b want 1 0 0 0 0", ws[i],
                     g_rdy(ws[i]), g_ov(ws[i]), g_y(ws[i]), g_co(ws[i]), g_ovf(ws[i]));
         else n_pass++;
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_directed16();
      do_op(16, 64'h1234, 64'h0FFF, 1'b0, 64'h2233, 1'b0, 1'b0, "add_1234_0fff");
      do_op(16, 64'hFFFF, 64'h0001, 1'b0, 64'h0000, 1'b1, 1'b0, "add_ffff_0001");
      do_op(16, 64'h0005, 64'h0007, 1'b1, 64'hFFFE, 1'b0, 1'b0, "sub_0005_0007");
      do_op(16, 64'h8000, 64'h0001, 1'b1, 64'h7FFF, 1'b1, 1'b1, "sub_8000_0001");
   endtask

   task automatic test_random16();
      for (int i = 0; i < 24; i++) rand_op(16, "rand16");
   endtask

   task automatic test_hold_backpressure();
      longint unsigned ey, ey2, xa, xb;
      logic eco, eov, eco2, eov2, xs, bad;
      int k;
      model(16, 64'hA5C3, 64'h3C5A, 1'b1, ey, eco, eov);
      drive(16, 1'b1, 64'hA5C3, 64'h3C5A, 1'b1, 1'b0);
      tick();
      bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(16, 1'b1, 64'($urandom), 64'($urandom), 1'($urandom_range(1)), 1'b0);
         if (ir16 !== 1'b0 || ov16 !== 1'b0) bad = 1'b1;
         tick();
      end
      n_total++;
      if (bad) $display("FAIL hold_run: got in_ready/out_valid asserted during RUN want both 0");
      else n_pass++;
      bad = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (ov16 !== 1'b1 || ir16 !== 1'b0 || y16 !== ey[15:0] || co16 !== eco) bad = 1'b1;
`ifdef NSADD_OVF_EN
         if (f16 !== eov) bad = 1'b1;
`endif
         drive(16, 1'b1, 64'($urandom), 64'($urandom), 1'($urandom_range(1)), 1'b0);
         tick();
      end
      n_total++;
      if (bad) $display("FAIL hold_done: got y=%h co=%b valid=%b ready=%b want y=%h co=%b valid=1 ready=0",
                        y16, co16, ov16, ir16, ey[15:0], eco);
      else n_pass++;
      xa = 64'($urandom_range(16'hFFFF));
      xb = 64'($urandom_range(16'hFFFF));
      xs = 1'($urandom_range(1));
      drive(16, 1'b1, xa, xb, xs, 1'b1);
      tick();
      n_total++;
      if (ir16 !== 1'b1 || ov16 !== 1'b0 || y16 !== ey[15:0])
         $display("FAIL hold_release: got ready=%b valid=%b y=%h want 1 0 %h", ir16, ov16, y16, ey[15:0]);
      else n_pass++;
      drive(16, 1'b1, xa, xb, xs, 1'b0);
      tick();
      drive(16, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
      k = 1;
      while (ov16 !== 1'b1 && k < 40) begin
         tick();
         k++;
      end
      model(16, xa, xb, xs, ey2, eco2, eov2);
      n_total++;
      if (k !== 5 || y16 !== ey2[15:0] || co16 !== eco2)
         $display("FAIL hold_next_op: got lat=%0d y=%h co=%b want 5 %h %b", k, y16, co16, ey2[15:0], eco2);
      else n_pass++;
      drive(16, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
      tick();
      drive(16, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      longint unsigned oa[3], ob[3], ey;
      logic os[3];
      logic eco, eov;
      int si, ri, last;
      for (int i = 0; i < 3; i++) begin
         oa[i] = 64'($urandom_range(16'hFFFF));
         ob[i] = 64'($urandom_range(16'hFFFF));
         os[i] = 1'($urandom_range(1));
      end
      drive(16, 1'b1, oa[0], ob[0], os[0], 1'b1);
      si = 1;
      ri = 0;
      last = 0;
      for (int cyc = 0; cyc < 60 && ri < 3; cyc++) begin
         tick();
         if (ir16 === 1'b1) begin
            if (si < 3) begin
               drive(16, 1'b1, oa[si], ob[si], os[si], 1'b1);
               si++;
            end else begin
               drive(16, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
            end
         end
         if (ov16 === 1'b1) begin
            model(16, oa[ri], ob[ri], os[ri], ey, eco, eov);
            n_total++;
            if (y16 !== ey[15:0] || co16 !== eco)
               $display("FAIL b2b_result%0d: got y=%h co=%b want %h %b", ri, y16, co16, ey[15:0], eco);
            else n_pass++;
            if (ri > 0) begin
               n_total++;
               if (cyc - last !== 6) $display("FAIL b2b_interval%0d: got %0d want 6", ri, cyc - last);
               else n_pass++;
            end
            last = cyc;
            ri++;
         end
      end
      n_total++;
      if (ri !== 3) $display("FAIL b2b_count: got %0d results want 3", ri);
      else n_pass++;
      tick();
      drive(16, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid_run();
      logic seen;
      drive(16, 1'b1, 64'h1234, 64'h1111, 1'b0, 1'b1);
      tick();
      drive(16, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      n_total++;
      if (ir16 !== 1'b1 || ov16 !== 1'b0 || y16 !== 16'h0000 || co16 !== 1'b0 || g_ovf(16) !== 1'b0)
         $display("FAIL midrun_reset: got ready=%b valid=%b y=%h co=%b want 1 0 0000 0", ir16, ov16, y16, co16);
      else n_pass++;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (ov16 !== 1'b0) seen = 1'b1;
         tick();
      end
      n_total++;
      if (seen) $display("FAIL midrun_no_valid: got out_valid=1 want 0 after reset");
      else n_pass++;
      drive(16, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
      do_op(16, 64'h7FFF, 64'h0001, 1'b0, 64'h8000, 1'b0, 1'b1, "after_reset_add");
   endtask

   task automatic test_width4_32();
      do_op(4, 64'h9, 64'h8, 1'b0, 64'h1, 1'b1, 1'b1, "w4_add_9_8");
      do_op(4, 64'h3, 64'h5, 1'b1, 64'hE, 1'b0, 1'b0, "w4_sub_3_5");
      do_op(32, 64'h89AB_CDEF, 64'h7654_3211, 1'b0, 64'h0, 1'b1, 1'b0, "w32_add_wrap");
      do_op(32, 64'h7FFF_FFFF, 64'hFFFF_FFFF, 1'b1, 64'h8000_0000, 1'b0, 1'b1, "w32_sub_ovf");
      for (int i = 0; i < 6; i++) begin
         rand_op(4, "rand4");
         rand_op(32, "rand32");
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      drive(4, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
      drive(16, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
      drive(32, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
      test_reset();
      test_directed16();
      test_random16();
      test_hold_backpressure();
      test_back_to_back();
      test_reset_mid_run();
      test_width4_32();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/nibble_serial_addsub.md
# nibble_serial_addsub

Multi-cycle add/subtract engine that processes an arbitrary-width operand pair four bits per clock through a single 4-bit adder slice, with a registered carry between nibbles. It generalises our per-nibble 74AC283 carry chain from a fully unrolled combinational chain to a time-multiplexed datapath. Board-level designs use it to trade package count for latency. It sits between a valid/ready operand source and a valid/ready result sink.

## Interface
- `WIDTH`, 16: operand and result width in bits. Must be a multiple of 4 and ≥ 4; elaboration error otherwise.
- `NIBBLES`, WIDTH/4: derived localparam, not overridable.

- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the `clk` rising edge.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  engine idle and able to accept operands.
- `in_a`  in  WIDTH  minuend or augend.
- `in_b`  in  WIDTH  subtrahend or addend.
- `in_sub`  in  1  0 = A+B, 1 = A−B.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  sink accepts the result.
- `out_y`  out  WIDTH  sum or difference, modulo 2^WIDTH.
- `out_co`  out  1  carry out of the MSB. In subtract mode, 1 means no borrow (A ≥ B unsigned).
- `out_ovf`  out  1  signed overflow. Present only with `NSADD_OVF_EN`.

## Operation
- State machine: IDLE → RUN → DONE → IDLE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`, capture `in_a` and the operand B. B is captured as `in_b` when `in_sub`=0, or `~in_b` when `in_sub`=1.
  - Set the carry register to `in_sub` and the nibble counter to 0, then go to RUN.
- RUN:
  - Each cycle, add nibble[cnt] of A, nibble[cnt] of B and the carry register.
  - Shift the 4-bit sum into the result register from the top, so after NIBBLES shifts the nibble order is correct.
  - Update the carry register with the slice carry out and increment cnt.
  - When cnt == NIBBLES−1, go to DONE after this cycle's update.
  - `in_valid` is ignored in RUN; `in_ready`=0.
- DONE:
  - `out_valid`=1; `out_y`, `out_co` and `out_ovf` are held stable.
  - On `out_ready`, go to IDLE. No new operand is accepted in the same cycle.
- The result register and flags update only in RUN, so outputs keep the last result in IDLE.
- Arithmetic:
  - Unsigned modulo 2^WIDTH.
  - `out_co` is the final carry register value.
  - `out_ovf` = (carry into bit WIDTH−1) XOR `out_co`. The carry into bit WIDTH−1 equals A[W−1] ^ B'[W−1] ^ Y[W−1], where B' is the captured (possibly inverted) B.
- Reset (`rst_n`=0 at a rising edge), including mid-RUN or mid-DONE:
  - State returns to IDLE; counter, carry, result and flags clear to 0.
  - The operation in flight is discarded with no `out_valid`.

## Timing
- Reset values:
  - `in_ready`=1 (state IDLE).
  - `out_valid`=0, `out_y`=0, `out_co`=0, `out_ovf`=0.
- Accept edge: the rising edge where IDLE ∧ `in_valid`.
- `out_valid` rises exactly NIBBLES+1 edges after the accept edge, i.e. NIBBLES RUN cycles.
- Minimum initiation interval is NIBBLES+2 cycles, reached when `out_ready` is held high.
- `in_ready` and `out_valid` are decoded from registered state only; there is no combinational path from inputs to outputs.
- `out_ready` low holds DONE indefinitely with the outputs unchanged.

## Configuration
- `NSADD_OVF_EN` defined:
  - `out_ovf` port exists.
  - The top-nibble carry-in is tracked to form the flag, which is registered with the final nibble.
- `NSADD_OVF_EN` undefined:
  - The `out_ovf` port and its logic are absent.
  - All other behaviour is identical.

## Structure
- Shared package `nsadd_pkg` holds:
  - the state enum (`NSADD_IDLE`, `NSADD_RUN`, `NSADD_DONE`);
  - the nibble width constant `NSADD_SLICE` = 4;
  - a function returning the counter width, $clog2(NIBBLES) with a minimum of 1.
- One sub-module, `nsadd_slice4`: a purely combinational 4-bit adder (A, B, CI → S, CO), the single instance synthesis maps onto one 74AC283 package.

## Test plan
- WIDTH=16, add 0x1234 + 0x0FFF → `out_y`=0x2233, `out_co`=0, `out_ovf`=0; `out_valid` 5 edges after accept.
- WIDTH=16, add 0xFFFF + 0x0001 → `out_y`=0x0000, `out_co`=1, `out_ovf`=0.
- WIDTH=16, subtract 0x0005 − 0x0007 → `out_y`=0xFFFE, `out_co`=0, `out_ovf`=0.
- WIDTH=16, subtract 0x8000 − 0x0001 → `out_y`=0x7FFF, `out_co`=1, `out_ovf`=1.
- Hold `out_ready`=0 for 5 cycles in DONE, with `in_valid`=1 and new operands pulsed during RUN and DONE → outputs stable, `in_ready`=0 throughout, new operands accepted only after the DONE→IDLE transition.
- WIDTH=4 and WIDTH=32 sanity sums.
- Assert `rst_n`=0 during the second RUN cycle → next cycle IDLE, all outputs 0, no `out_valid`; the following operation computes correctly.
